// File: rtl/lif_layer_net.sv
// lif_layer_net: N_IN hidden leaky integrate-and-fire neurons, each fed by its
// own unsigned current, drive one output LIF neuron through programmable signed
// synaptic weights. Pipeline: current -> l1_spike (+1) -> weighted sum (+2) ->
// output neuron / spike_out / state_out (+3). All state freezes when en=0,
// except the weight table, which accepts writes regardless of en.
module lif_layer_net #(
    parameter int N_IN       = 8,
    parameter int IN_W       = 8,
    parameter int STATE_W    = 8,
    parameter int W_W        = 4,
    parameter int THRESH     = 32,
    parameter int OUT_THRESH = 4,
    parameter int LEAK_SHIFT = 3,
    parameter int REFRACT    = 2,
    parameter int DEFAULT_W  = 1,
    parameter int CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [N_IN*IN_W-1:0]   current,
    input  logic                   wr_en,
    input  logic [3:0]             wr_addr,
    input  logic [W_W-1:0]         wr_data,
    output logic [N_IN-1:0]        l1_spike,
    output logic                   spike_out,
    output logic [STATE_W-1:0]     state_out,
    output logic [CNT_W-1:0]       spike_count
);

    // Sum of up to N_IN signed weights cannot overflow at this width.
    localparam int SUM_W = W_W + $clog2(N_IN) + 1;
    localparam int RF_W  = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
    // Hidden update: membrane plus current, one spare bit to detect saturation.
    localparam int HN_W  = ((IN_W > STATE_W) ? IN_W : STATE_W) + 1;
    // Output update: signed, room for a negative sum and a full membrane.
    localparam int ON_W  = ((SUM_W > STATE_W) ? SUM_W : STATE_W) + 2;

    localparam logic [STATE_W-1:0]     MEM_MAX = {STATE_W{1'b1}};
    localparam logic signed [ON_W-1:0] O_MAX   = {{(ON_W-STATE_W){1'b0}}, {STATE_W{1'b1}}};
    localparam logic [CNT_W-1:0]       CNT_MAX = {CNT_W{1'b1}};

    // Leak amount for one update; a zero shift means no leak at all.
    function automatic logic [STATE_W-1:0] leak_of(input logic [STATE_W-1:0] m);
        if (LEAK_SHIFT > 0) begin
            leak_of = m >> LEAK_SHIFT;
        end else begin
            leak_of = '0;
        end
    endfunction

    // Hidden layer state
    logic [STATE_W-1:0]     mem_r      [N_IN];
    logic [RF_W-1:0]        refr_r     [N_IN];
    logic [N_IN-1:0]        l1_spike_r;
    logic [STATE_W-1:0]     mem_nxt_s  [N_IN];
    logic [RF_W-1:0]        refr_nxt_s [N_IN];
    logic [N_IN-1:0]        spk_nxt_s;
    logic [HN_W-1:0]        h_raw_s    [N_IN];
    logic [STATE_W-1:0]     h_clip_s   [N_IN];

    // Synapses and sum stage
    logic [W_W-1:0]         w_r        [N_IN];
    logic signed [SUM_W-1:0] sum_r;
    logic signed [SUM_W-1:0] sum_nxt_s;

    // Output neuron
    logic [STATE_W-1:0]     out_mem_r;
    logic [RF_W-1:0]        out_refr_r;
    logic                   spike_out_r;
    logic [CNT_W-1:0]       spike_count_r;
    logic signed [ON_W-1:0] o_mem_ext_s;
    logic signed [ON_W-1:0] o_leak_ext_s;
    logic signed [ON_W-1:0] o_in_ext_s;
    logic signed [ON_W-1:0] o_raw_s;
    logic [STATE_W-1:0]     o_clip_s;
    logic [STATE_W-1:0]     out_mem_nxt_s;
    logic [RF_W-1:0]        out_refr_nxt_s;
    logic                   out_spk_nxt_s;
    logic [CNT_W-1:0]       cnt_nxt_s;

    // Hidden neurons: leak, integrate with saturation, fire and subtract threshold.
    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            h_raw_s[i] = HN_W'(mem_r[i]) - HN_W'(leak_of(mem_r[i]))
                       + HN_W'(current[i*IN_W +: IN_W]);
            if (h_raw_s[i] > HN_W'(MEM_MAX)) begin
                h_clip_s[i] = MEM_MAX;
            end else begin
                h_clip_s[i] = h_raw_s[i][STATE_W-1:0];
            end
            if (refr_r[i] != '0) begin
                mem_nxt_s[i]  = mem_r[i];
                refr_nxt_s[i] = refr_r[i] - RF_W'(1);
                spk_nxt_s[i]  = 1'b0;
            end else if (h_clip_s[i] >= STATE_W'(THRESH)) begin
                mem_nxt_s[i]  = h_clip_s[i] - STATE_W'(THRESH);
                refr_nxt_s[i] = RF_W'(REFRACT);
                spk_nxt_s[i]  = 1'b1;
            end else begin
                mem_nxt_s[i]  = h_clip_s[i];
                refr_nxt_s[i] = '0;
                spk_nxt_s[i]  = 1'b0;
            end
        end
    end

    // Weighted sum of the registered hidden spikes, weights sign-extended.
    always_comb begin
        sum_nxt_s = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (l1_spike_r[i]) begin
                sum_nxt_s = sum_nxt_s + {{(SUM_W-W_W){w_r[i][W_W-1]}}, w_r[i]};
            end else begin
                sum_nxt_s = sum_nxt_s;
            end
        end
    end

    // Output neuron: signed integrate clamped to [0, MEM_MAX], then fire/refractory.
    always_comb begin
        o_mem_ext_s  = {{(ON_W-STATE_W){1'b0}}, out_mem_r};
        o_leak_ext_s = {{(ON_W-STATE_W){1'b0}}, leak_of(out_mem_r)};
        o_in_ext_s   = {{(ON_W-SUM_W){sum_r[SUM_W-1]}}, sum_r};
        o_raw_s      = o_mem_ext_s - o_leak_ext_s + o_in_ext_s;
        if (o_raw_s[ON_W-1]) begin
            o_clip_s = '0;
        end else if (o_raw_s > O_MAX) begin
            o_clip_s = MEM_MAX;
        end else begin
            o_clip_s = o_raw_s[STATE_W-1:0];
        end
        if (out_refr_r != '0) begin
            out_mem_nxt_s  = out_mem_r;
            out_refr_nxt_s = out_refr_r - RF_W'(1);
            out_spk_nxt_s  = 1'b0;
        end else if (o_clip_s >= STATE_W'(OUT_THRESH)) begin
            out_mem_nxt_s  = o_clip_s - STATE_W'(OUT_THRESH);
            out_refr_nxt_s = RF_W'(REFRACT);
            out_spk_nxt_s  = 1'b1;
        end else begin
            out_mem_nxt_s  = o_clip_s;
            out_refr_nxt_s = '0;
            out_spk_nxt_s  = 1'b0;
        end
        if (out_spk_nxt_s && (spike_count_r != CNT_MAX)) begin
            cnt_nxt_s = spike_count_r + CNT_W'(1);
        end else begin
            cnt_nxt_s = spike_count_r;
        end
    end

    // Neuron, sum and counter state: cleared on reset, advanced only when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_IN; i++) begin
                mem_r[i]  <= '0;
                refr_r[i] <= '0;
            end
            l1_spike_r    <= '0;
            sum_r         <= '0;
            out_mem_r     <= '0;
            out_refr_r    <= '0;
            spike_out_r   <= 1'b0;
            spike_count_r <= '0;
        end else if (en) begin
            for (int i = 0; i < N_IN; i++) begin
                mem_r[i]  <= mem_nxt_s[i];
                refr_r[i] <= refr_nxt_s[i];
            end
            l1_spike_r    <= spk_nxt_s;
            sum_r         <= sum_nxt_s;
            out_mem_r     <= out_mem_nxt_s;
            out_refr_r    <= out_refr_nxt_s;
            spike_out_r   <= out_spk_nxt_s;
            spike_count_r <= cnt_nxt_s;
        end else begin
            l1_spike_r    <= l1_spike_r;
            spike_out_r   <= spike_out_r;
        end
    end

    // Weight table: reset to the default weight, out-of-range addresses never match.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_IN; i++) begin
                w_r[i] <= W_W'(DEFAULT_W);
            end
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (wr_en && (wr_addr == 4'(i))) begin
                    w_r[i] <= wr_data;
                end else begin
                    w_r[i] <= w_r[i];
                end
            end
        end
    end

    assign l1_spike    = l1_spike_r;
    assign spike_out   = spike_out_r;
    assign state_out   = out_mem_r;
    assign spike_count = spike_count_r;

endmodule

// File: tb/tb_lif_layer_net.sv
// Bench for lif_layer_net: two instances (default parameters, and a small
// no-leak/no-refractory variant with a 3-bit counter) driven by the same
// stimulus and compared every cycle against an integer reference model.
module tb_lif_layer_net;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en, wr_en;
    logic [3:0]  wr_addr, wr_data;
    logic [63:0] current_a;
    logic [39:0] current_b;
    logic [7:0]  l1_a;
    logic [4:0]  l1_b;
    logic        spk_a, spk_b;
    logic [7:0]  st_a, st_b;
    logic [15:0] cnt_a;
    logic [2:0]  cnt_b;

    int cur [8];
    int n_vec = 0;
    int n_err = 0;

    lif_layer_net dut_a (
        .clk(clk), .rst(rst), .en(en), .current(current_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .l1_spike(l1_a), .spike_out(spk_a), .state_out(st_a), .spike_count(cnt_a)
    );

    lif_layer_net #(
        .N_IN(5), .IN_W(8), .STATE_W(8), .W_W(4), .THRESH(255), .OUT_THRESH(3),
        .LEAK_SHIFT(0), .REFRACT(0), .DEFAULT_W(2), .CNT_W(3)
    ) dut_b (
        .clk(clk), .rst(rst), .en(en), .current(current_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .l1_spike(l1_b), .spike_out(spk_b), .state_out(st_b), .spike_count(cnt_b)
    );

    // Reference model parameters per instance (index 0 = dut_a, 1 = dut_b)
    int P_N    [2] = '{8, 5};
    int P_THR  [2] = '{32, 255};
    int P_OTH  [2] = '{4, 3};
    int P_LK   [2] = '{3, 0};
    int P_RF   [2] = '{2, 0};
    int P_DW   [2] = '{1, 2};
    int P_CMAX [2] = '{65535, 7};

    int m_mem [2][8];
    int m_refr[2][8];
    int m_l1  [2][8];
    int m_w   [2][8];
    int m_sum [2];
    int m_om  [2];
    int m_orf [2];
    int m_osp [2];
    int m_cnt [2];

    function automatic int clamp_next(input int mem, input int inp, input int lk);
        int nx;
        nx = mem - ((lk > 0) ? (mem >> lk) : 0) + inp;
        if (nx < 0) nx = 0;
        if (nx > 255) nx = 255;
        return nx;
    endfunction

    task automatic model_step(input int k);
        int ns, nx;
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                m_mem[k][i] = 0; m_refr[k][i] = 0; m_l1[k][i] = 0; m_w[k][i] = P_DW[k];
            end
            m_sum[k] = 0; m_om[k] = 0; m_orf[k] = 0; m_osp[k] = 0; m_cnt[k] = 0;
        end else begin
            if (en) begin
                ns = 0;
                for (int i = 0; i < P_N[k]; i++)
                    if (m_l1[k][i] != 0) ns += m_w[k][i];
                if (m_orf[k] > 0) begin
                    m_orf[k]--; m_osp[k] = 0;
                end else begin
                    nx = clamp_next(m_om[k], m_sum[k], P_LK[k]);
                    if (nx >= P_OTH[k]) begin
                        m_osp[k] = 1; m_om[k] = nx - P_OTH[k]; m_orf[k] = P_RF[k];
                        if (m_cnt[k] < P_CMAX[k]) m_cnt[k]++;
                    end else begin
                        m_osp[k] = 0; m_om[k] = nx;
                    end
                end
                for (int i = 0; i < P_N[k]; i++) begin
                    if (m_refr[k][i] > 0) begin
                        m_refr[k][i]--; m_l1[k][i] = 0;
                    end else begin
                        nx = clamp_next(m_mem[k][i], cur[i], P_LK[k]);
                        if (nx >= P_THR[k]) begin
                            m_l1[k][i] = 1; m_mem[k][i] = nx - P_THR[k]; m_refr[k][i] = P_RF[k];
                        end else begin
                            m_l1[k][i] = 0; m_mem[k][i] = nx;
                        end
                    end
                end
                m_sum[k] = ns;
            end
            if (wr_en && (int'(wr_addr) < P_N[k]))
                m_w[k][wr_addr] = (wr_data >= 4'd8) ? int'(wr_data) - 16 : int'(wr_data);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 8; i++) current_a[i*8 +: 8] = 8'(cur[i]);
        for (int i = 0; i < 5; i++) current_b[i*8 +: 8] = 8'(cur[i]);
    endtask

    task automatic check_all();
        logic [7:0] ea;
        logic [4:0] eb;
        ea = '0; eb = '0;
        for (int i = 0; i < 8; i++) ea[i] = (m_l1[0][i] != 0);
        for (int i = 0; i < 5; i++) eb[i] = (m_l1[1][i] != 0);
        chk("a_l1_spike", 32'(l1_a), 32'(ea));
        chk("a_spike_out", 32'(spk_a), m_osp[0]);
        chk("a_state_out", 32'(st_a), m_om[0]);
        chk("a_spike_count", 32'(cnt_a), m_cnt[0]);
        chk("b_l1_spike", 32'(l1_b), 32'(eb));
        chk("b_spike_out", 32'(spk_b), m_osp[1]);
        chk("b_state_out", 32'(st_b), m_om[1]);
        chk("b_spike_count", 32'(cnt_b), m_cnt[1]);
    endtask

    task automatic step();
        drive();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_all();
    endtask

    task automatic set_all(input int v);
        for (int i = 0; i < 8; i++) cur[i] = v;
    endtask

    task automatic do_reset();
        rst = 1'b1; step(); rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 4'd0;
        set_all(0);
        #2;

        // Reset state
        step();
        chk("rst_l1", 32'(l1_a), 32'd0);
        chk("rst_state", 32'(st_a), 32'd0);
        chk("rst_count", 32'(cnt_a), 32'd0);
        rst = 1'b0; en = 1'b1;

        // Small constant current into neuron 0 with leak
        cur[0] = 4;
        repeat (40) step();

        // All neurons fire together; output spikes three cycles after the input
        do_reset();
        set_all(32);
        step();
        chk("all_fire_l1", 32'(l1_a), 32'hFF);
        step();
        step();
        chk("all_fire_spike", 32'(spk_a), 32'd1);
        chk("all_fire_state", 32'(st_a), 32'd4);
        chk("all_fire_count", 32'(cnt_a), 32'd1);
        repeat (6) step();

        // Negative weight on neuron 0, then an out-of-range write
        do_reset();
        set_all(0);
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 4'hD; step();
        wr_addr = 4'd9; wr_data = 4'h7; step();
        wr_en = 1'b0;
        cur[0] = 32; step();
        cur[0] = 0; step(); step();
        chk("neg_w_state", 32'(st_a), 32'd0);
        chk("neg_w_spike", 32'(spk_a), 32'd0);
        repeat (4) step();

        // Saturating current on dut_b (threshold 255, no leak): fires every cycle
        do_reset();
        cur[0] = 255;
        for (int n = 0; n < 20; n++) begin
            step();
            chk("sat_l1_b", 32'(l1_b), 32'h1);
        end
        chk("sat_count_b", 32'(cnt_b), 32'd7);

        // Reset mid-burst overriding en=0 and a weight write
        set_all(32);
        repeat (5) step();
        rst = 1'b1; en = 1'b0; wr_en = 1'b1; wr_addr = 4'd0; wr_data = 4'h7;
        step();
        chk("midrst_l1_a", 32'(l1_a), 32'd0);
        chk("midrst_spike_a", 32'(spk_a), 32'd0);
        chk("midrst_state_a", 32'(st_a), 32'd0);
        chk("midrst_count_a", 32'(cnt_a), 32'd0);
        chk("midrst_count_b", 32'(cnt_b), 32'd0);
        rst = 1'b0; en = 1'b1; wr_en = 1'b0;
        step(); step(); step();
        chk("default_w_state", 32'(st_a), 32'd4);
        chk("default_w_spike", 32'(spk_a), 32'd1);

        // Freeze with en=0 while currents and weight writes keep changing
        en = 1'b0;
        for (int n = 0; n < 10; n++) begin
            for (int i = 0; i < 8; i++) cur[i] = int'($urandom_range(0, 255));
            wr_en = 1'($urandom_range(0, 1));
            wr_addr = 4'($urandom_range(0, 15));
            wr_data = 4'($urandom_range(0, 15));
            step();
        end

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            en = ($urandom_range(0, 7) != 0);
            wr_en = ($urandom_range(0, 3) == 0);
            wr_addr = 4'($urandom_range(0, 15));
            wr_data = 4'($urandom_range(0, 15));
            for (int i = 0; i < 8; i++)
                cur[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 255))
                                                      : int'($urandom_range(0, 40));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
